booth_skip_controller: RTL



---
 rtl/booth_skip_controller_pkg.sv | 18 +
 rtl/booth_skip_finder.sv | 38 +++
 rtl/booth_skip_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/booth_skip_controller_pkg.sv
// Shared constants and types for the Booth skip controller and its bit-transition finder.
// The optional op counter is enabled by defining BOOTH_OPCNT_EN (see booth_skip_controller.sv).
package booth_skip_controller_pkg;

  localparam int WIDTH_DEF = 4;
  localparam int SHW_DEF   = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic OP_ADD = 1'b1;
  localparam logic OP_SUB = 1'b0;

endpackage

// File: rtl/booth_skip_finder.sv
// Combinational search for the lowest bit transition of the live B register within the
// remaining (unconsumed) bit window; prev stands in for the bit just below B[0].
module booth_skip_finder
  import booth_skip_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic [WIDTH-1:0] b,
  input  logic             prev,
  input  logic [SHW-1:0]   rem,
  output logic             found,
  output logic [SHW-1:0]   k,
  output logic             new_bit
);

  logic [WIDTH-1:0] lower;
  logic [WIDTH-1:0] diff;

  assign lower = {b[WIDTH-2:0], prev};
  assign diff  = b ^ lower;

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    found   = 1'b0;
    k       = '0;
    new_bit = 1'b0;
    // Scan downward so the lowest qualifying index is the one that sticks.
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (diff[i] && (SHW'(i) < rem)) begin
        found   = 1'b1;
        k       = SHW'(i);
        new_bit = b[i];
      end
    end
  end

endmodule

// File: rtl/booth_skip_controller.sv
// Booth-recoding skip controller: issues one non-zero partial product per RUN cycle to the
// shift/accumulate datapath. Define BOOTH_OPCNT_EN to add the op_cnt output.
module booth_skip_controller
  import booth_skip_controller_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SHW   = SHW_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] B,
  output logic             dp_rstN,
  output logic [SHW-1:0]   A_shft_amt,
  output logic [SHW-1:0]   B_shft_amt,
  output logic             op,
  output logic             done,
  output logic             busy,
  output logic             result_valid
`ifdef BOOTH_OPCNT_EN
  ,
  output logic [SHW-1:0]   op_cnt
`endif
);

  state_t         state;
  state_t         next_state;
  logic [SHW-1:0] pos;
  logic           prev;
  logic [SHW-1:0] rem;
  logic           found;
  logic [SHW-1:0] k;
  logic           new_bit;
  logic           accept;
  logic           issue;

  // pos counts consumed bits; it never exceeds WIDTH, so rem cannot wrap.
  assign rem    = SHW'(WIDTH) - pos;
  assign accept = (state == IDLE) && start;
  assign issue  = (state == RUN) && found;

  booth_skip_finder #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_finder (
    .b       (B),
    .prev    (prev),
    .rem     (rem),
    .found   (found),
    .k       (k),
    .new_bit (new_bit)
  );

  always_comb begin
    next_state = state;
    done       = 1'b1;
    busy       = 1'b0;
    op         = OP_SUB;
    A_shft_amt = '0;
    B_shft_amt = '0;
    case (state)
      IDLE: if (start) next_state = LOAD;
      LOAD: begin
        busy       = 1'b1;
        next_state = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (found) begin
          done       = 1'b0;
          op         = new_bit ? OP_SUB : OP_ADD;
          A_shft_amt = pos + k;
          B_shft_amt = k + SHW'(1);
        end else begin
          next_state = DONE;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos          <= '0;
      prev         <= 1'b0;
      dp_rstN      <= 1'b1;
      result_valid <= 1'b0;
    end else begin
      // Strobe is low exactly for the LOAD cycle following an accepted start.
      dp_rstN      <= !accept;
      result_valid <= (next_state == DONE);
      if (accept) begin
        pos  <= '0;
        prev <= 1'b0;
      end else if (issue) begin
        pos  <= pos + k + SHW'(1);
        prev <= new_bit;
      end
    end
  end

`ifdef BOOTH_OPCNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 op_cnt <= '0;
    else if (state == LOAD)  op_cnt <= '0;
    else if (issue)          op_cnt <= op_cnt + SHW'(1);
  end
`endif

  a_pos_bounded: assert property (@(posedge clk) disable iff (rst) pos <= SHW'(WIDTH));
  a_rv_in_done:  assert property (@(posedge clk) disable iff (rst) result_valid |-> state == DONE);
  a_bshift_ok:   assert property (@(posedge clk) disable iff (rst)
                                  !done |-> (B_shft_amt != '0) && (B_shft_amt <= SHW'(WIDTH)));

endmodule
